hqm_system_mem_rf_pg_fifo_ctl: RTL and testbench
================================================

// Module: hqm_system_mem_rf_pg_fifo_ctl
// PURPOSE
// - Client-side FIFO controller driving a power-gated 2-port RF (64x30).
// - Generates write/read port traffic and the RF power/isolation handshake.
// - Wakes the RF on demand; powers it down after an idle window when empty.
// - Sits between an HQM system producer/consumer pair and the RF memory wrapper.
// PARAMETERS
// - DEPTH       64   RF entries (power of 2)
// - DWIDTH      30   data width
// - AWIDTH      6    log2(DEPTH)
// - IDLE_LIMIT  200  empty+idle cycles in PG_ON before power-down (>=1)
// - IDLE_W      8    idle counter width; must hold IDLE_LIMIT
// PORTS
// - clk                   in   1         single clock
// - rst                   in   1         async assert, active-high reset
// - push_valid            in   1         producer data valid
// - push_ready            out  1         accept; push fires on valid&&ready
// - push_data             in   DWIDTH    producer data
// - pop_valid             out  1         head entry valid
// - pop_ready             in   1         consumer accept; pop fires on valid&&ready
// - pop_data              out  DWIDTH    head entry
// - count                 out  AWIDTH+1  mem_cnt + inflight + buf_occ (max DEPTH+2)
// - pwr_down_en           in   1         1 = idle power-down allowed
// - pwr_on                out  1         1 = state PG_ON
// - mem_we                out  1         RF write enable
// - mem_waddr             out  AWIDTH    RF write address (wp)
// - mem_wdata             out  DWIDTH    RF write data (= push_data)
// - mem_re                out  1         RF read enable
// - mem_raddr             out  AWIDTH    RF read address (rp)
// - mem_rdata             in   DWIDTH    RF read data, valid cycle after mem_re
// - mem_pgcb_isol_en      out  1         RF output isolation, 1 = isolated
// - mem_pwr_enable_b_in   out  1         RF power enable, active-low
// - mem_pwr_enable_b_out  in   1         RF power-good, 0 = powered
// BEHAVIOUR
// - Reset: state PG_OFF; wp/rp/mem_cnt/inflight/buf/idle = 0.
// - Reset outputs: push_ready, pop_valid, mem_we, mem_re, pwr_on = 0.
// - Reset outputs: count = 0; mem_pgcb_isol_en = 1; mem_pwr_enable_b_in = 1.
// - Reset mid-operation: all contents discarded, RF isolated and powered off.
// - PG FSM states:
//   - PG_OFF: b_in=1, iso=1; push_valid -> PG_WAKE.
//   - PG_WAKE: b_in=0, iso=1; mem_pwr_enable_b_out==0 -> PG_DEISO; waits forever.
//   - PG_DEISO: b_in=0, iso=0, one cycle -> PG_ON.
//   - PG_ON: idle hits IDLE_LIMIT -> PG_ISO.
//   - PG_ISO: iso=1, b_in=0, one cycle -> PG_OFF; a push_valid here is held off.
// - Idle counter (PG_ON only):
//   - Increments when count==0, !push_valid, pwr_down_en, no inflight; else clears.
//   - Saturates at IDLE_LIMIT.
// - push_ready = PG_ON && mem_cnt<DEPTH; push is not gated by pop in the same cycle.
// - Push fire: mem_we=1, waddr=wp, wp++ (wraps DEPTH-1->0), mem_cnt++.
// - Read issue: mem_re=1, raddr=rp, rp++ (wrap), mem_cnt--.
//   - Requires PG_ON && mem_cnt>0 && (buf_occ+inflight-pop_fire)<2.
// - inflight = registered mem_re; when set, mem_rdata is written into the 2-entry output buffer.
// - pop_valid = buf_occ>0; pop_data = oldest buffer entry; order is FIFO.
// - Push and read issue in the same cycle are legal; mem_cnt is net unchanged.
// - wp==rp with a write and a read in the same cycle cannot occur: a read needs
//   mem_cnt>0 and a write needs mem_cnt<DEPTH.
// - Latency: push fire in cycle N -> read issue N+1 -> buffer capture end of N+2
//   -> pop_valid in N+3.
// - Throughput: 1 push + 1 pop per cycle sustained.
// - Full: mem_cnt==DEPTH drops push_ready; count can reach DEPTH+2.
// - Empty: no mem_re while mem_cnt==0; pop_valid=0 when buf_occ==0.
// - Power-down only from count==0, so no data is lost by gating.
// - mem_re and mem_we are never asserted outside PG_ON.
// STRUCTURE
// - Package hqm_system_mem_pg_pkg holds:
//   - pg_state_t enum {PG_OFF, PG_WAKE, PG_DEISO, PG_ON, PG_ISO}.
//   - PG output encoding constants.
// - Sub-module hqm_system_mem_pg_seq: PG FSM + idle counter.
//   - Outputs: iso, b_in, pwr_on.
// - Top level: pointers, counters, read issue, 2-entry output buffer.
// TESTING
// - Reset, then push 0x1 -> PG_WAKE; b_out=0 after 5 cycles -> PG_DEISO, PG_ON; push accepted;
//   pop_valid 3 cycles later with pop_data=0x1.
// - Fill: pop_ready=0, push 66 values 0..65 -> push_ready low after mem_cnt=64; count=66;
//   drain -> values 0..65 in order.
// - Streaming: push+pop every cycle for 200 cycles -> no bubble after the first pop_valid;
//   wp/rp wrap; data in order.
// - Idle: pwr_down_en=1, empty for 200 cycles -> PG_ISO (iso=1), then PG_OFF (b_in=1);
//   pwr_down_en=0 -> stays PG_ON.
// - Assert rst with 10 entries queued mid-stream -> count=0, pop_valid=0, iso=1, b_in=1
//   in the same cycle.

Source files
------------

// File: rtl/hqm_system_mem_pg_pkg.sv
// Shared definitions for the power-gated RF FIFO controller.
// - Default geometry and idle-window parameters.
// - pg_state_t: power-gating sequencer states.
// - pg_out_t: registered RF power/isolation controls, plus the
//   per-state encoding and a lookup function for it.
package hqm_system_mem_pg_pkg;

  localparam int DEPTH      = 64;
  localparam int DWIDTH     = 30;
  localparam int AWIDTH     = 6;
  localparam int IDLE_LIMIT = 200;
  localparam int IDLE_W     = 8;

  typedef enum logic [2:0] {
    PG_OFF   = 3'd0,
    PG_WAKE  = 3'd1,
    PG_DEISO = 3'd2,
    PG_ON    = 3'd3,
    PG_ISO   = 3'd4
  } pg_state_t;

  // iso: 1 = RF outputs isolated; b_in: active-low power enable;
  // pwr_on: 1 only in PG_ON.
  typedef struct packed {
    logic iso;
    logic b_in;
    logic pwr_on;
  } pg_out_t;

  localparam pg_out_t PG_OUT_OFF   = '{iso: 1'b1, b_in: 1'b1, pwr_on: 1'b0};
  localparam pg_out_t PG_OUT_WAKE  = '{iso: 1'b1, b_in: 1'b0, pwr_on: 1'b0};
  localparam pg_out_t PG_OUT_DEISO = '{iso: 1'b0, b_in: 1'b0, pwr_on: 1'b0};
  localparam pg_out_t PG_OUT_ON    = '{iso: 1'b0, b_in: 1'b0, pwr_on: 1'b1};
  localparam pg_out_t PG_OUT_ISO   = '{iso: 1'b1, b_in: 1'b0, pwr_on: 1'b0};

  function automatic pg_out_t pg_out_of(input pg_state_t s);
    pg_out_t r;
    case (s)
      PG_OFF:   r = PG_OUT_OFF;
      PG_WAKE:  r = PG_OUT_WAKE;
      PG_DEISO: r = PG_OUT_DEISO;
      PG_ON:    r = PG_OUT_ON;
      PG_ISO:   r = PG_OUT_ISO;
      default:  r = PG_OUT_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hqm_system_mem_pg_seq.sv
// Power-gating sequencer for the RF: OFF -> WAKE -> DEISO -> ON -> ISO -> OFF.
// Ports:
//   clk, rst        clock, async active-high reset
//   push_valid      producer request; wakes the RF from PG_OFF
//   pwr_down_en     1 = idle power-down allowed
//   drained         FIFO holds nothing (no RF entries, nothing in flight/buffered)
//   pwr_good_b      RF power-good, 0 = powered
//   iso, b_in       registered RF isolation / active-low power enable
//   pwr_on          registered, 1 exactly while state == PG_ON
//   state           current sequencer state (observable for checkers)
module hqm_system_mem_pg_seq
  import hqm_system_mem_pg_pkg::*;
#(
  parameter int IDLE_LIMIT = hqm_system_mem_pg_pkg::IDLE_LIMIT,
  parameter int IDLE_W     = hqm_system_mem_pg_pkg::IDLE_W
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_valid,
  input  logic      pwr_down_en,
  input  logic      drained,
  input  logic      pwr_good_b,
  output logic      iso,
  output logic      b_in,
  output logic      pwr_on,
  output pg_state_t state
);

  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_LIMIT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

  pg_out_t           out_q;
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_cond;

  // A cycle counts as idle only if nothing could need the RF right now,
  // so leaving PG_ON on such a cycle can never strand data.
  assign idle_cond = drained && !push_valid && pwr_down_en;

  assign iso    = out_q.iso;
  assign b_in   = out_q.b_in;
  assign pwr_on = out_q.pwr_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PG_OFF;
      out_q    <= PG_OUT_OFF;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= '0;
      unique case (state)
        PG_OFF: begin
          if (push_valid) begin
            state <= PG_WAKE;
            out_q <= pg_out_of(PG_WAKE);
          end
        end
        PG_WAKE: begin
          // No timeout: the RF wrapper must eventually report power-good.
          if (!pwr_good_b) begin
            state <= PG_DEISO;
            out_q <= pg_out_of(PG_DEISO);
          end
        end
        PG_DEISO: begin
          state <= PG_ON;
          out_q <= pg_out_of(PG_ON);
        end
        PG_ON: begin
          if (idle_cond) begin
            // The transition is taken on the IDLE_LIMIT-th idle cycle itself,
            // so push_ready is already low on the next cycle.
            if (idle_cnt >= IDLE_LAST) begin
              idle_cnt <= IDLE_MAX;
              state    <= PG_ISO;
              out_q    <= pg_out_of(PG_ISO);
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end
        PG_ISO: begin
          state <= PG_OFF;
          out_q <= pg_out_of(PG_OFF);
        end
        default: begin
          state <= PG_OFF;
          out_q <= PG_OUT_OFF;
        end
      endcase
    end
  end

endmodule

// File: rtl/hqm_system_mem_rf_pg_fifo_ctl.sv
// Client-side FIFO controller for a power-gated 2-port RF (DEPTH x DWIDTH).
// Drives RF write/read traffic, keeps a 2-entry output buffer that hides
// the one-cycle RF read latency, and sequences RF power/isolation.
// Ports:
//   clk, rst                         clock, async active-high reset
//   push_valid/push_ready/push_data  producer side
//   pop_valid/pop_ready/pop_data     consumer side
//   count                            entries held (RF + in flight + buffer)
//   pwr_down_en, pwr_on              power-down enable, 1 = RF in PG_ON
//   mem_we/mem_waddr/mem_wdata       RF write port
//   mem_re/mem_raddr/mem_rdata       RF read port (data one cycle after mem_re)
//   mem_pgcb_isol_en                 RF isolation, 1 = isolated
//   mem_pwr_enable_b_in/_out         RF power enable / power-good, active-low
module hqm_system_mem_rf_pg_fifo_ctl
  import hqm_system_mem_pg_pkg::*;
#(
  parameter int DEPTH      = hqm_system_mem_pg_pkg::DEPTH,
  parameter int DWIDTH     = hqm_system_mem_pg_pkg::DWIDTH,
  parameter int AWIDTH     = hqm_system_mem_pg_pkg::AWIDTH,
  parameter int IDLE_LIMIT = hqm_system_mem_pg_pkg::IDLE_LIMIT,
  parameter int IDLE_W     = hqm_system_mem_pg_pkg::IDLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DWIDTH-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DWIDTH-1:0] pop_data,
  output logic [AWIDTH:0]   count,
  input  logic              pwr_down_en,
  output logic              pwr_on,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              mem_pgcb_isol_en,
  output logic              mem_pwr_enable_b_in,
  input  logic              mem_pwr_enable_b_out
);

  localparam int CW = AWIDTH + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // push_ready depends only on state and RF occupancy, never on push_valid
  // or on a pop in the same cycle; pop_valid depends only on buffer
  // occupancy. Neither ready waits on the matching valid.

  pg_state_t         pg_state;
  logic              on_st;
  logic [AWIDTH-1:0] wp;
  logic [AWIDTH-1:0] rp;
  logic [CW-1:0]     mem_cnt;
  logic              inflight;
  logic [DWIDTH-1:0] buf_q [2];
  logic              buf_wr;
  logic              buf_rd;
  logic [1:0]        buf_occ;
  logic [2:0]        occ_after;
  logic              push_fire;
  logic              pop_fire;
  logic              rd_issue;

  hqm_system_mem_pg_seq #(
    .IDLE_LIMIT (IDLE_LIMIT),
    .IDLE_W     (IDLE_W)
  ) u_pg_seq (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .pwr_down_en (pwr_down_en),
    .drained     ((count == '0) && !inflight),
    .pwr_good_b  (mem_pwr_enable_b_out),
    .iso         (mem_pgcb_isol_en),
    .b_in        (mem_pwr_enable_b_in),
    .pwr_on      (pwr_on),
    .state       (pg_state)
  );

  assign on_st      = (pg_state == PG_ON);
  assign push_ready = on_st && (mem_cnt < CW'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign pop_valid  = (buf_occ != 2'd0);
  assign pop_fire   = pop_valid && pop_ready;
  assign pop_data   = buf_q[buf_rd];

  // Buffer slots that will be taken once everything already requested has
  // landed, after this cycle's pop. Issuing only below 2 means a returning
  // read always finds a free slot, so the RF read port needs no stall.
  assign occ_after = 3'(buf_occ) + 3'(inflight) - 3'(pop_fire);
  assign rd_issue  = on_st && (mem_cnt != '0) && (occ_after < 3'd2);

  assign mem_we    = push_fire;
  assign mem_waddr = wp;
  assign mem_wdata = push_data;
  assign mem_re    = rd_issue;
  assign mem_raddr = rp;

  assign count = mem_cnt + CW'(inflight) + CW'(buf_occ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (push_fire) wp <= wp + AWIDTH'(1);
      if (rd_issue)  rp <= rp + AWIDTH'(1);
      unique case ({push_fire, rd_issue})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_wr   <= 1'b0;
      buf_rd   <= 1'b0;
      buf_occ  <= 2'd0;
    end else begin
      if (inflight) begin
        buf_q[buf_wr] <= mem_rdata;
        buf_wr        <= ~buf_wr;
      end
      if (pop_fire) buf_rd <= ~buf_rd;
      buf_occ <= buf_occ + 2'(inflight) - 2'(pop_fire);
    end
  end

endmodule

// File: tb/tb_hqm_system_mem_rf_pg_fifo_ctl.sv
module tb_hqm_system_mem_rf_pg_fifo_ctl;

  localparam int DEPTH  = 64;
  localparam int DWIDTH = 30;
  localparam int AWIDTH = 6;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              push_valid;
  logic              push_ready;
  logic [DWIDTH-1:0] push_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [DWIDTH-1:0] pop_data;
  logic [AWIDTH:0]   count;
  logic              pwr_down_en;
  logic              pwr_on;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_re;
  logic [AWIDTH-1:0] mem_raddr;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_pgcb_isol_en;
  logic              mem_pwr_enable_b_in;
  logic              mem_pwr_enable_b_out;

  hqm_system_mem_rf_pg_fifo_ctl dut (
    .clk                  (clk),
    .rst                  (rst),
    .push_valid           (push_valid),
    .push_ready           (push_ready),
    .push_data            (push_data),
    .pop_valid            (pop_valid),
    .pop_ready            (pop_ready),
    .pop_data             (pop_data),
    .count                (count),
    .pwr_down_en          (pwr_down_en),
    .pwr_on               (pwr_on),
    .mem_we               (mem_we),
    .mem_waddr            (mem_waddr),
    .mem_wdata            (mem_wdata),
    .mem_re               (mem_re),
    .mem_raddr            (mem_raddr),
    .mem_rdata            (mem_rdata),
    .mem_pgcb_isol_en     (mem_pgcb_isol_en),
    .mem_pwr_enable_b_in  (mem_pwr_enable_b_in),
    .mem_pwr_enable_b_out (mem_pwr_enable_b_out)
  );

  // ---------------- RF model ----------------
  logic [DWIDTH-1:0] rf [DEPTH];
  logic [DWIDTH-1:0] rdata_q;
  logic [1:0]        b_dly;
  logic              pg_auto;
  logic              b_man;
  int                cyc;

  always @(posedge clk) begin
    if (mem_we) rf[mem_waddr] <= mem_wdata;
    if (mem_re) rdata_q <= rf[mem_raddr];
    b_dly <= {b_dly[0], mem_pwr_enable_b_in};
    cyc   <= cyc + 1;
  end

  assign mem_rdata            = rdata_q;
  assign mem_pwr_enable_b_out = pg_auto ? b_dly[1] : b_man;

  // ---------------- scoreboard state ----------------
  logic [DWIDTH-1:0] exp_q[$];
  int checks;
  int errors;
  int exp_wp;
  int exp_rp;
  int stalls;
  int pop_cnt;
  int first_pop_cyc;
  int last_pop_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (mem_we || mem_re) check("mem_access_only_on", 32'(pwr_on), 32'd1);
        if (mem_re) begin
          check("mem_raddr", 32'(mem_raddr), 32'(exp_rp));
          exp_rp = (exp_rp + 1) % DEPTH;
        end
        if (pop_valid && pop_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no pop", pop_data);
          end else begin
            logic [DWIDTH-1:0] e;
            e = exp_q.pop_front();
            check("pop_data", 32'(pop_data), 32'(e));
          end
          if (pop_cnt == 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          pop_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DWIDTH-1:0] d, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = d;
    #1;
    while (!push_ready && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    stalls += n;
    if (push_ready) begin
      exp_q.push_back(d);
      check("mem_we", 32'(mem_we), 32'd1);
      check("mem_waddr", 32'(mem_waddr), 32'(exp_wp));
      check("mem_wdata", 32'(mem_wdata), 32'(d));
      exp_wp = (exp_wp + 1) % DEPTH;
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout: push_ready 0 after %0d cycles, expected 1", budget);
    end
  endtask

  task automatic push_idle();
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    #3;
    while ((count != '0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    push_valid  = 1'b0;
    push_data   = '0;
    pop_ready   = 1'b0;
    pwr_down_en = 1'b0;
    pg_auto     = 1'b0;
    b_man       = 1'b1;
    checks      = 0;
    errors      = 0;
    exp_wp      = 0;
    exp_rp      = 0;
    stalls      = 0;
    pop_cnt     = 0;
    first_pop_cyc = 0;
    last_pop_cyc  = 0;
    cyc         = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_pwr_on", 32'(pwr_on), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_iso", 32'(mem_pgcb_isol_en), 32'd1);
    check("rst_b_in", 32'(mem_pwr_enable_b_in), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("off_no_req_b_in", 32'(mem_pwr_enable_b_in), 32'd1);

    // Wake on demand with a slow power-good
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 30'h1;
    @(negedge clk);
    #1;
    check("wake_b_in", 32'(mem_pwr_enable_b_in), 32'd0);
    check("wake_iso", 32'(mem_pgcb_isol_en), 32'd1);
    check("wake_pwr_on", 32'(pwr_on), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("wake_hold_b_in", 32'(mem_pwr_enable_b_in), 32'd0);
    check("wake_hold_iso", 32'(mem_pgcb_isol_en), 32'd1);
    check("wake_hold_push_ready", 32'(push_ready), 32'd0);
    b_man = 1'b0;
    @(negedge clk);
    #1;
    check("deiso_iso", 32'(mem_pgcb_isol_en), 32'd0);
    check("deiso_b_in", 32'(mem_pwr_enable_b_in), 32'd0);
    check("deiso_pwr_on", 32'(pwr_on), 32'd0);
    push_word(30'h1, 4);
    check("on_pwr_on", 32'(pwr_on), 32'd1);
    check("on_iso", 32'(mem_pgcb_isol_en), 32'd0);
    @(negedge clk);
    push_valid = 1'b0;
    #1;
    check("lat_read_issue_n1", 32'(mem_re), 32'd1);
    check("lat_pop_valid_n1", 32'(pop_valid), 32'd0);
    @(negedge clk);
    #1;
    check("lat_pop_valid_n2", 32'(pop_valid), 32'd0);
    check("lat_count_n2", 32'(count), 32'd1);
    @(negedge clk);
    #1;
    check("lat_pop_valid_n3", 32'(pop_valid), 32'd1);
    pop_ready = 1'b1;
    wait_drain(20);
    pg_auto = 1'b1;

    // Fill to DEPTH+2 then drain in order
    pop_ready = 1'b0;
    stalls    = 0;
    for (int i = 0; i < DEPTH + 2; i++) push_word(30'(i), 4);
    check("fill_no_stall", 32'(stalls), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_data = 30'd66;
      #1;
      check("full_push_ready", 32'(push_ready), 32'd0);
      check("full_mem_we", 32'(mem_we), 32'd0);
    end
    check("full_count", 32'(count), 32'd66);
    push_idle();
    pop_ready = 1'b1;
    wait_drain(200);

    // Streaming: one push and one pop per cycle
    pop_cnt = 0;
    stalls  = 0;
    for (int i = 0; i < 200; i++) push_word(30'h3FFF0000 | 30'(i), 4);
    push_idle();
    wait_drain(50);
    check("stream_pops", 32'(pop_cnt), 32'd200);
    check("stream_span", 32'(last_pop_cyc - first_pop_cyc + 1), 32'd200);
    check("stream_no_stall", 32'(stalls), 32'd0);

    // Idle: no power-down while disabled
    repeat (250) @(negedge clk);
    #1;
    check("idle_disabled_pwr_on", 32'(pwr_on), 32'd1);
    check("idle_disabled_iso", 32'(mem_pgcb_isol_en), 32'd0);
    // Idle: power-down after exactly 200 idle cycles
    @(negedge clk);
    pwr_down_en = 1'b1;
    repeat (199) @(negedge clk);
    #1;
    check("idle_199_pwr_on", 32'(pwr_on), 32'd1);
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 30'h55;
    #1;
    check("iso_iso", 32'(mem_pgcb_isol_en), 32'd1);
    check("iso_b_in", 32'(mem_pwr_enable_b_in), 32'd0);
    check("iso_pwr_on", 32'(pwr_on), 32'd0);
    check("iso_push_held", 32'(push_ready), 32'd0);
    check("iso_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    #1;
    check("off_b_in", 32'(mem_pwr_enable_b_in), 32'd1);
    check("off_iso", 32'(mem_pgcb_isol_en), 32'd1);
    pwr_down_en = 1'b0;
    pop_ready   = 1'b1;
    push_word(30'h55, 20);
    push_idle();
    wait_drain(20);

    // Reset with 10 entries queued
    pop_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(30'h15550000 + 30'(i), 4);
    push_idle();
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_count", 32'(count), 32'd10);
    check("pre_rst_pop_valid", 32'(pop_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_wp = 0;
    exp_rp = 0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_pop_valid", 32'(pop_valid), 32'd0);
    check("midrst_iso", 32'(mem_pgcb_isol_en), 32'd1);
    check("midrst_b_in", 32'(mem_pwr_enable_b_in), 32'd1);
    check("midrst_pwr_on", 32'(pwr_on), 32'd0);
    check("midrst_push_ready", 32'(push_ready), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    pop_ready = 1'b1;
    push_word(30'h0123456, 20);
    push_idle();
    wait_drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
